// File: rtl/cross_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cross_pattern_gen                                          |
// | Description : Free-running bitmap sequencer that paints a 12-row heart    |
// |               across signal1..signal12, one column per HOLD_CYCLES clocks.|
// |               Optional macro LOOP_EN: repeat the frame forever; without  |
// |               it the frame plays once and the outputs then stay at zero. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cross_pattern_gen #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   output logic signal1,
   output logic signal2,
   output logic signal3,
   output logic signal4,
   output logic signal5,
   output logic signal6,
   output logic signal7,
   output logic signal8,
   output logic signal9,
   output logic signal10,
   output logic signal11,
   output logic signal12
);

   localparam int          C_HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [C_HW-1:0] C_HMAX = C_HW'(HOLD_CYCLES - 1);
   localparam logic [4:0]  C_COL_LAST = 5'd15;
   localparam logic [4:0]  C_COL_DONE = 5'd16;

   logic [C_HW-1:0] r_h;
   logic [4:0]      r_c;
   logic [11:0]     r_p;

   logic            w_col_end;
   logic [4:0]      w_c_next;
   logic [11:0]     w_rom;

   // Heart bitmap, bit i = row i+1; columns 13..16 are blank
   always_comb begin
      w_rom = 12'h000;
      case (r_c)
         5'd0:    w_rom = 12'h01C;
         5'd1:    w_rom = 12'h03E;
         5'd2:    w_rom = 12'h07F;
         5'd3:    w_rom = 12'h0FF;
         5'd4:    w_rom = 12'h1FF;
         5'd5:    w_rom = 12'h3FE;
         5'd6:    w_rom = 12'h7FC;
         5'd7:    w_rom = 12'h3FE;
         5'd8:    w_rom = 12'h1FF;
         5'd9:    w_rom = 12'h0FF;
         5'd10:   w_rom = 12'h07F;
         5'd11:   w_rom = 12'h03E;
         5'd12:   w_rom = 12'h01C;
         default: w_rom = 12'h000;
      endcase
   end

   assign w_col_end = (r_h == C_HMAX);

   always_comb begin
      w_c_next = r_c;
      if (r_c == C_COL_LAST) begin
`ifdef LOOP_EN
         w_c_next = 5'd0;
`else
         w_c_next = C_COL_DONE;
`endif
      end else if (r_c != C_COL_DONE) begin
         w_c_next = r_c + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_h <= '0;
         r_c <= '0;
         r_p <= '0;
      end else begin
         r_p <= w_rom;
         if (w_col_end) begin
            r_h <= '0;
            r_c <= w_c_next;
         end else begin
            r_h <= r_h + 1'b1;
         end
      end
   end

   assign signal1  = r_p[0];
   assign signal2  = r_p[1];
   assign signal3  = r_p[2];
   assign signal4  = r_p[3];
   assign signal5  = r_p[4];
   assign signal6  = r_p[5];
   assign signal7  = r_p[6];
   assign signal8  = r_p[7];
   assign signal9  = r_p[8];
   assign signal10 = r_p[9];
   assign signal11 = r_p[10];
   assign signal12 = r_p[11];

endmodule
`default_nettype wire

// File: tb/tb_cross_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cross_pattern_gen                                       |
// | Description : Directed self-checking bench, HOLD_CYCLES=4 and =1 copies. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cross_pattern_gen;

   logic        clk;
   logic        reset;
   logic [11:0] w_p4;
   logic [11:0] w_p1;
   int          r_checks;
   int          r_errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cross_pattern_gen #(.HOLD_CYCLES(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .signal1(w_p4[0]), .signal2(w_p4[1]), .signal3(w_p4[2]), .signal4(w_p4[3]),
      .signal5(w_p4[4]), .signal6(w_p4[5]), .signal7(w_p4[6]), .signal8(w_p4[7]),
      .signal9(w_p4[8]), .signal10(w_p4[9]), .signal11(w_p4[10]), .signal12(w_p4[11])
   );

   cross_pattern_gen #(.HOLD_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .signal1(w_p1[0]), .signal2(w_p1[1]), .signal3(w_p1[2]), .signal4(w_p1[3]),
      .signal5(w_p1[4]), .signal6(w_p1[5]), .signal7(w_p1[6]), .signal8(w_p1[7]),
      .signal9(w_p1[8]), .signal10(w_p1[9]), .signal11(w_p1[10]), .signal12(w_p1[11])
   );

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      r_checks++;
      if (got !== exp) begin
         r_errors++;
         $display("FAIL %s: got %03h expected %03h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] heart_col(input int col);
      logic [11:0] c_tab [0:15];
      c_tab = '{12'h01C, 12'h03E, 12'h07F, 12'h0FF, 12'h1FF, 12'h3FE, 12'h7FC, 12'h3FE,
                12'h1FF, 12'h0FF, 12'h07F, 12'h03E, 12'h01C, 12'h000, 12'h000, 12'h000};
      return c_tab[col];
   endfunction

   // Expected word on edge n after release for a given hold length
   function automatic logic [11:0] exp_word(input int n, input int hold);
      int col;
      if (n < 1) return 12'h000;
      col = (n - 1) / hold;
`ifdef LOOP_EN
      col = col % 16;
`else
      if (col > 15) return 12'h000;
`endif
      return heart_col(col);
   endfunction

   initial begin
      r_checks = 0;
      r_errors = 0;
      reset    = 1'b0;

      // Reset held: outputs zero at both phases of two clocks
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_hi4", w_p4, 12'h000);
         check("rst_hi1", w_p1, 12'h000);
         @(negedge clk); #1;
         check("rst_lo4", w_p4, 12'h000);
         check("rst_lo1", w_p1, 12'h000);
      end

      @(negedge clk);
      reset = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk); #1;
         check($sformatf("h4_e%0d", n), w_p4, exp_word(n, 4));
         check($sformatf("h1_e%0d", n), w_p1, exp_word(n, 1));
         check($sformatf("s12_e%0d", n), {11'd0, w_p4[11] | w_p1[11]}, 12'h000);
         if (n == 1)  check("h4_first", w_p4, 12'h01C);
         if (n == 25) check("h4_col6",  w_p4, 12'h7FC);
         if (n == 49) check("h4_col12", w_p4, 12'h01C);
         if (n == 7)  check("h1_col6",  w_p1, 12'h7FC);
         if (n == 53) check("h4_blank", w_p4, 12'h000);
`ifdef LOOP_EN
         if (n == 65)  check("h4_loop1", w_p4, 12'h01C);
         if (n == 129) check("h4_loop2", w_p4, 12'h01C);
`else
         if (n == 65)  check("h4_oneshot", w_p4, 12'h000);
`endif
      end

      // Mid-frame async reset, asserted between edge 30 and edge 31
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
      end
      check("h4_e30_pre", w_p4, 12'h3FE);
      #2;
      reset = 1'b0;
      #1;
      check("async4", w_p4, 12'h000);
      check("async1", w_p1, 12'h000);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("restart4", w_p4, 12'h01C);
      check("restart1", w_p1, 12'h01C);
      @(posedge clk); #1;
      check("restart1_e2", w_p1, 12'h03E);
      check("restart4_e2", w_p4, 12'h01C);

      $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cross_pattern_gen.md
# cross_pattern_gen

Free-running bitmap sequencer that paints a 12-row heart picture across twelve 1-bit outputs, one column at a time, so the waveform viewer displays the shape. It is a self-contained stimulus/demo block with no data inputs: a column counter indexes a fixed 16-column ROM, and each column is held for a programmable number of clocks. It sits at top level and is driven only by clock and reset.

## Interface
- HOLD_CYCLES, 4, clocks each column is held; legal range 1..256.
- clk  input  1  rising-edge clock.
- reset  input  1  one clock; reset is asynchronous and active-low (port named `reset`, asserted at 0).
- signal1..signal12  output  1 each  pixel rows; signal1 = top row, signal12 = bottom row; registered.

## Operation
- Word view: P[11:0] = {signal12..signal1}; bit i = row i+1.
- ROM, 16 columns, fixed contents (hex P):
  - col0 01C, col1 03E, col2 07F, col3 0FF, col4 1FF, col5 3FE, col6 7FC, col7 3FE
  - col8 1FF, col9 0FF, col10 07F, col11 03E, col12 01C, col13 000, col14 000, col15 000.
- Columns 0-12 form the heart (symmetric about col6, tip at row 11); columns 13-15 are blank spacing.
- signal12 is therefore always 0; it is still a real registered output.
- State: hold counter h (0..HOLD_CYCLES-1), column counter c (5 bits, 0..16), output register P.
- Every rising edge while reset=1:
  - P <= ROM[c] (ROM[16] = 000).
  - If h == HOLD_CYCLES-1: h <= 0 and c advances (see Configuration); else h <= h+1.
- No other inputs; behaviour is fully deterministic from reset release.

## Timing
- reset=0: P=000, h=0, c=0 immediately (async), held while low.
- Release synchronised to the clock edge only through normal flop behaviour; no internal synchroniser.
- Edge n after release = the n-th rising edge with reset=1.
- Column k appears on edges k*HOLD_CYCLES+1 through (k+1)*HOLD_CYCLES; latency from release to first pixel = 1 edge.
- Frame length = 16*HOLD_CYCLES clocks.
- HOLD_CYCLES=1: a new column every edge, no gaps.
- Reset mid-frame: outputs drop to 000 asynchronously; after release the frame restarts at col0 on edge 1.

## Configuration
- Macro LOOP_EN.
- Defined: after col15 completes, c wraps to 0; the heart repeats forever with period 16*HOLD_CYCLES.
- Not defined: after col15 completes, c saturates at 16 and P stays 000 until the next reset (one-shot).

## Test plan
- Hold reset=0 for 2 clocks -> all twelve outputs 0 throughout, including between edges.
- HOLD_CYCLES=4, release reset -> P=01C on edges 1-4, 03E on edges 5-8, 7FC on edges 25-28 (signal11=1 only in col6), 01C on edges 49-52.
- Same run, edges 53-64 -> P=000; signal12=0 on every edge of the run.
- LOOP_EN defined, 400-clock run -> P=01C again on edges 65-68 and 129-132; without LOOP_EN -> P=000 from edge 53 onward.
- Assert reset=0 asynchronously at edge 30 (mid col7) -> P=000 before the next edge; after release, edge 1 shows 01C.
- HOLD_CYCLES=1 -> P steps 01C,03E,07F,0FF,1FF,3FE,7FC,3FE,... on consecutive edges 1,2,3,...
